// File: rtl/tpu_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_feed_sequencer
//  Function : Weight loader and diagonally skewed data streamer for a
//             DEPTH x DEPTH weight-stationary systolic array.
//  Revision : 1.0  initial release
// ============================================================================
module tpu_feed_sequencer #(
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [BIT_WIDTH*DEPTH-1:0]   wt_in,
    input  logic                         wt_in_valid,
    output logic                         wt_in_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]   data_in,
    input  logic                         data_in_valid,
    input  logic                         data_in_last,
    output logic                         data_in_ready,
    output logic                         control,
    output logic [BIT_WIDTH*DEPTH-1:0]   wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]   data_arr,
    output logic [15:0]                  vec_count
);

    localparam int DRAIN  = 2*DEPTH-1;
    localparam int WCNT_W = $clog2(DEPTH)+1;
    localparam int DCNT_W = $clog2(DRAIN);
    localparam int VEC_W  = BIT_WIDTH*DEPTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_WT = 3'd1,
        S_SETTLE  = 3'd2,
        S_STREAM  = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [15:0]         vec_count_q, vec_count_d;
    logic                control_q, control_d;
    logic [VEC_W-1:0]    wt_arr_q, wt_arr_d;
    logic [VEC_W-1:0]    inject;
    logic                wt_hs, data_hs;

    assign busy          = (state_q != S_IDLE);
    assign wt_in_ready   = (state_q == S_LOAD_WT);
    assign data_in_ready = (state_q == S_STREAM);
    assign done          = (state_q == S_DRAIN) && (dcnt_q == DCNT_W'(DRAIN-1));
    assign wt_hs         = wt_in_valid & wt_in_ready;
    assign data_hs       = data_in_valid & data_in_ready;
    assign control       = control_q;
    assign wt_arr        = wt_arr_q;
    assign vec_count     = vec_count_q;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        dcnt_d      = dcnt_q;
        vec_count_d = vec_count_q;
        control_d   = 1'b0;
        wt_arr_d    = wt_arr_q;
        inject      = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD_WT;
                    wcnt_d      = '0;
                    vec_count_d = '0;
                end
            end
            S_LOAD_WT: begin
                if (wt_hs) begin
                    control_d = 1'b1;
                    wt_arr_d  = wt_in;
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == WCNT_W'(DEPTH-1)) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                wt_arr_d = '0;
                state_d  = S_STREAM;
            end
            S_STREAM: begin
                // Cycles without a handshake inject zeros, which the array ignores
                if (data_hs) begin
                    inject = data_in;
                    if (vec_count_q != 16'hFFFF) begin
                        vec_count_d = vec_count_q + 16'd1;
                    end
                    if (data_in_last) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + DCNT_W'(1);
                if (dcnt_q == DCNT_W'(DRAIN-1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            vec_count_q <= '0;
            control_q   <= 1'b0;
            wt_arr_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            dcnt_q      <= dcnt_d;
            vec_count_q <= vec_count_d;
            control_q   <= control_d;
            wt_arr_q    <= wt_arr_d;
        end
    end

    // Lane i passes through i+1 registers, giving the diagonal wavefront
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_lane
            logic [BIT_WIDTH-1:0] skew_q [0:i];
            logic [BIT_WIDTH-1:0] skew_d [0:i];

            always_comb begin
                skew_d[0] = inject[i*BIT_WIDTH +: BIT_WIDTH];
                for (int j = 1; j <= i; j++) begin
                    skew_d[j] = skew_q[j-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j <= i; j++) begin
                        skew_q[j] <= '0;
                    end
                end else begin
                    skew_q <= skew_d;
                end
            end

            assign data_arr[i*BIT_WIDTH +: BIT_WIDTH] = skew_q[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tpu_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpu_feed_sequencer
//  Function : Self-checking bench for tpu_feed_sequencer against a
//             job-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tpu_feed_sequencer;
    localparam int BW = 16;
    localparam int D  = 4;
    localparam int VW = BW*D;

    logic          clk = 1'b0;
    logic          rst, start, wt_in_valid, data_in_valid, data_in_last;
    logic [VW-1:0] wt_in, data_in, wt_arr, data_arr;
    logic          busy, done, wt_in_ready, data_in_ready, control;
    logic [15:0]   vec_count;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    tpu_feed_sequencer #(.BIT_WIDTH(BW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .wt_in(wt_in), .wt_in_valid(wt_in_valid), .wt_in_ready(wt_in_ready),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
        .data_in_ready(data_in_ready), .control(control), .wt_arr(wt_arr),
        .data_arr(data_arr), .vec_count(vec_count)
    );

    // Reference model: phase 0 idle, 1 weights, 2 settle, 3 stream, 4 drain
    int            m_ph, m_words, m_drain, m_vec;
    logic          m_ctrl;
    logic [VW-1:0] m_wt;
    logic [VW-1:0] m_hist [0:D-1];

    function automatic void model_reset();
        m_ph = 0; m_words = 0; m_drain = 0; m_vec = 0; m_ctrl = 1'b0; m_wt = '0;
        for (int k = 0; k < D; k++) m_hist[k] = '0;
    endfunction

    function automatic void model_step();
        logic [VW-1:0] inj = '0;
        logic          nctrl = 1'b0;
        case (m_ph)
            0: if (start) begin m_ph = 1; m_words = 0; m_vec = 0; end
            1: if (wt_in_valid) begin
                   m_wt = wt_in; nctrl = 1'b1; m_words++;
                   if (m_words == D) m_ph = 2;
               end
            2: begin m_wt = '0; m_ph = 3; end
            3: if (data_in_valid) begin
                   inj = data_in;
                   if (m_vec < 65535) m_vec++;
                   if (data_in_last) begin m_ph = 4; m_drain = 2*D-1; end
               end
            default: begin m_drain--; if (m_drain == 0) m_ph = 0; end
        endcase
        m_ctrl = nctrl;
        for (int k = D-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = inj;
    endfunction

    // Lane i shows lane i of the vector injected i+1 edges ago
    function automatic logic [VW-1:0] exp_data();
        logic [VW-1:0] r = '0;
        for (int i = 0; i < D; i++) r[i*BW +: BW] = m_hist[i][i*BW +: BW];
        return r;
    endfunction

    function automatic logic exp_done();
        return (m_ph == 4) && (m_drain == 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [6*VW-1:0] z;
        rst = 1'b1; start = 0; wt_in_valid = 0; data_in_valid = 0; data_in_last = 0;
        wt_in = '0; data_in = '0;
        #2; model_reset();
        z = {busy, done, control, wt_in_ready, data_in_ready, vec_count, wt_arr, data_arr};
        checks++; if (z !== '0) begin errors++; $display("FAIL reset_init: got %h expected 0", z); end
        @(negedge clk); rst = 1'b0;
        // Start a job and reset asynchronously in the middle of streaming
        start = 1; cyc(); start = 0;
        wt_in_valid = 1;
        repeat (D) begin wt_in = {$urandom, $urandom}; cyc(); end
        wt_in_valid = 0; cyc();
        data_in_valid = 1;
        repeat (2) begin data_in = {$urandom, $urandom} | 64'h0001_0001_0001_0001; cyc(); end
        data_in_valid = 0;
        checks++; if (vec_count !== 16'd2) begin errors++; $display("FAIL pre_reset_count: got %0d expected 2", vec_count); end
        #2; rst = 1'b1; model_reset(); #1;
        z = {busy, done, control, wt_in_ready, data_in_ready, vec_count, wt_arr, data_arr};
        checks++; if (z !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", z); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_weights();
        logic [VW-1:0] w [0:D-1];
        w[0] = 64'h000a << 48; w[1] = 64'h000a << 32; w[2] = 64'h000a << 16; w[3] = 64'h000a;
        start = 1; cyc(); start = 0;
        checks++; if ({busy, wt_in_ready} !== 2'b11) begin errors++; $display("FAIL load_enter: got %b expected 11", {busy, wt_in_ready}); end
        wt_in_valid = 1;
        for (int k = 0; k < D; k++) begin
            wt_in = w[k]; cyc();
            checks++; if ({control, wt_arr} !== {1'b1, w[k]}) begin errors++; $display("FAIL wt_word%0d: got %b/%h expected 1/%h", k, control, wt_arr, w[k]); end
        end
        wt_in_valid = 1; wt_in = 64'hdead_beef_dead_beef;
        checks++; if (wt_in_ready !== 1'b0) begin errors++; $display("FAIL settle_ready: got %b expected 0", wt_in_ready); end
        cyc(); wt_in_valid = 0;
        checks++; if ({control, wt_arr, data_in_ready} !== {1'b0, 64'h0, 1'b1}) begin errors++; $display("FAIL settle_out: got %b/%h/%b expected 0/0/1", control, wt_arr, data_in_ready); end
    endtask

    task automatic test_skew();
        logic [VW-1:0] v [0:D-1];
        v[0] = 64'h000c_0008_0004_0000; v[1] = 64'h000d_0009_0005_0001;
        v[2] = 64'h000e_000a_0006_0002; v[3] = 64'h001e_000b_0007_0003;
        start = 1;   // ignored outside idle
        data_in_valid = 1;
        for (int k = 0; k < D; k++) begin
            data_in = v[k]; data_in_last = (k == D-1); cyc();
            checks++; if (data_arr[15:0] !== 16'(k)) begin errors++; $display("FAIL skew_lane0_%0d: got %h expected %h", k, data_arr[15:0], k); end
            checks++; if (data_arr !== exp_data()) begin errors++; $display("FAIL skew_vec%0d: got %h expected %h", k, data_arr, exp_data()); end
            checks++; if ({wt_in_ready, control} !== 2'b00) begin errors++; $display("FAIL start_ignored%0d: got %b expected 00", k, {wt_in_ready, control}); end
        end
        start = 0; data_in_last = 0;
        checks++; if (vec_count !== 16'd4) begin errors++; $display("FAIL skew_count: got %0d expected 4", vec_count); end
    endtask

    task automatic test_end();
        int n = 1;
        data_in_valid = 1; data_in = 64'hffff_ffff_ffff_ffff;   // must be ignored in drain
        while (!done && n < 20) begin
            checks++; if ({busy, data_in_ready, data_arr} !== {1'b1, 1'b0, exp_data()}) begin errors++; $display("FAIL drain%0d: got %b/%b/%h expected 1/0/%h", n, busy, data_in_ready, data_arr, exp_data()); end
            cyc(); n++;
        end
        checks++; if (n !== 2*D-1) begin errors++; $display("FAIL drain_len: got %0d expected %0d", n, 2*D-1); end
        checks++; if (data_arr !== 64'h0) begin errors++; $display("FAIL drain_zero: got %h expected 0", data_arr); end
        data_in_valid = 0;
        cyc();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL drain_exit: got %b expected 00", {busy, done}); end
        checks++; if (vec_count !== 16'd4) begin errors++; $display("FAIL count_hold: got %0d expected 4", vec_count); end
    endtask

    task automatic test_bubbles();
        int c = 0;
        start = 1; cyc(); start = 0;
        while (c < 80 && !(c > 0 && m_ph == 0)) begin
            wt_in_valid = (c % 2 == 0); wt_in = {$urandom, $urandom};
            data_in_valid = (c % 2 == 0); data_in = {$urandom, $urandom};
            data_in_last = (m_vec == 3);
            cyc(); c++;
            checks++; if ({control, wt_arr} !== {m_ctrl, m_wt}) begin errors++; $display("FAIL bub_wt%0d: got %b/%h expected %b/%h", c, control, wt_arr, m_ctrl, m_wt); end
            checks++; if ({data_arr, done} !== {exp_data(), exp_done()}) begin errors++; $display("FAIL bub_data%0d: got %h/%b expected %h/%b", c, data_arr, done, exp_data(), exp_done()); end
        end
        wt_in_valid = 0; data_in_valid = 0; data_in_last = 0;
        checks++; if (m_ph != 0) begin errors++; $display("FAIL bub_timeout: got phase %0d expected 0", m_ph); end
        checks++; if (vec_count !== 16'd4) begin errors++; $display("FAIL bub_count: got %0d expected 4", vec_count); end
    endtask

    task automatic test_random();
        for (int job = 0; job < 4; job++) begin
            int c = 0;
            int target = $urandom_range(6, 1);
            start = 1;
            while (c < 300 && !(c > 0 && m_ph == 0)) begin
                wt_in_valid = $urandom_range(1, 0); wt_in = {$urandom, $urandom};
                data_in_valid = $urandom_range(1, 0); data_in = {$urandom, $urandom};
                data_in_last = (m_vec + 1 >= target);
                cyc(); c++; start = 0;
                checks++; if ({busy, done, wt_in_ready, data_in_ready, control} !== {m_ph != 0, exp_done(), m_ph == 1, m_ph == 3, m_ctrl}) begin errors++; $display("FAIL rnd_ctl j%0d c%0d: got %b expected %b", job, c, {busy, done, wt_in_ready, data_in_ready, control}, {m_ph != 0, exp_done(), m_ph == 1, m_ph == 3, m_ctrl}); end
                checks++; if ({wt_arr, data_arr, vec_count} !== {m_wt, exp_data(), 16'(m_vec)}) begin errors++; $display("FAIL rnd_dat j%0d c%0d: got %h/%h/%0d expected %h/%h/%0d", job, c, wt_arr, data_arr, vec_count, m_wt, exp_data(), m_vec); end
            end
            checks++; if (m_ph != 0 || vec_count !== 16'(target)) begin errors++; $display("FAIL rnd_job%0d: got count %0d expected %0d", job, vec_count, target); end
        end
        wt_in_valid = 0; data_in_valid = 0; data_in_last = 0;
    endtask

    initial begin
        test_reset();
        test_weights();
        test_skew();
        test_end();
        test_bubbles();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
